// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller with 4-word lines and a serial refill port.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_ctrl #(
  parameter int unsigned LINES = 16,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC,
  input  logic        Flush,
  output logic [31:0] Instr,
  output logic        Stall,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemRData
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] HitCnt,
  output logic [31:0] MissCnt
`endif
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 28 - IW;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;

  logic [0:0]       state;
  logic [1:0]       cnt;
  logic             flush_pend;
  logic [27:0]      line_q;
  logic [LINES-1:0] valid;

  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*4];

  logic [1:0]       pc_off;
  logic [IW-1:0]    pc_idx;
  logic [TW-1:0]    pc_tag;
  logic [IW-1:0]    rf_idx;
  logic [TW-1:0]    rf_tag;

  logic             hit;
  logic             hit_go;
  logic             miss_go;
  logic             take_ack;
  logic             unused_pc;

  assign pc_off    = PC[3:2];
  assign pc_idx    = PC[4 +: IW];
  assign pc_tag    = PC[4+IW +: TW];
  assign rf_idx    = line_q[IW-1:0];
  assign rf_tag    = line_q[IW +: TW];
  assign unused_pc = ^PC[1:0];

  assign hit      = (state == IDLE) && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  assign hit_go   = hit && !Flush;
  assign miss_go  = (state == IDLE) && !hit && !Flush;
  assign take_ack = (state == REFILL) && MemAck;

  always_comb begin
    Instr   = NOP;
    Stall   = 1'b1;
    MemReq  = 1'b0;
    MemAddr = '0;
    if (state == REFILL) begin
      MemReq  = 1'b1;
      MemAddr = {line_q, cnt, 2'b00};
    end else if (hit_go) begin
      Instr = data_mem[{pc_idx, pc_off}];
      Stall = 1'b0;
    end
  end

  // The victim line is invalidated on refill entry so an aborted refill never leaves a stale hit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_pend <= 1'b0;
      line_q     <= '0;
      valid      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Flush) begin
            valid <= '0;
          end else if (miss_go) begin
            state          <= REFILL;
            line_q         <= PC[31:4];
            cnt            <= '0;
            valid[pc_idx]  <= 1'b0;
          end
        end
        REFILL: begin
          if (Flush) begin
            flush_pend <= 1'b1;
          end
          if (MemAck) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state      <= IDLE;
              flush_pend <= 1'b0;
              if (flush_pend || Flush) begin
                valid <= '0;
              end else begin
                valid[rf_idx] <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (take_ack) begin
      data_mem[{rf_idx, cnt}] <= MemRData;
      if (cnt == 2'd3) begin
        tag_mem[rf_idx] <= rf_tag;
      end
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      HitCnt  <= '0;
      MissCnt <= '0;
    end else begin
      if (hit_go) begin
        HitCnt <= HitCnt + 32'd1;
      end
      if (miss_go) begin
        MissCnt <= MissCnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed table-driven bench for icache_ctrl (LINES=16): fill, hit, eviction, flush and reset-abort cases.
module tb_icache_ctrl;

  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic        CLK;
  logic        RST;
  logic [31:0] PC;
  logic        Flush;
  logic [31:0] Instr;
  logic        Stall;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemRData;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] HitCnt;
  logic [31:0] MissCnt;
`endif

  icache_ctrl #(.LINES(16), .NOP(NOPI)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PC       (PC),
    .Flush    (Flush),
    .Instr    (Instr),
    .Stall    (Stall),
    .MemReq   (MemReq),
    .MemAddr  (MemAddr),
    .MemAck   (MemAck),
    .MemRData (MemRData)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .HitCnt   (HitCnt),
    .MissCnt  (MissCnt)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        ack;
    logic [31:0] rd;
    logic [31:0] instr;
    logic        stall;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t tv[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic [31:0] pc, input logic fl, input logic ack,
                              input logic [31:0] rd, input logic [31:0] instr,
                              input logic stall, input logic req, input logic [31:0] addr);
    vec_t v;
    v.pc = pc; v.fl = fl; v.ack = ack; v.rd = rd;
    v.instr = instr; v.stall = stall; v.req = req; v.addr = addr;
    tv.push_back(v);
  endfunction

  // Shorthands: IDLE miss, refill beat, IDLE hit.
  function automatic void miss(input logic [31:0] pc, input logic fl);
    add(pc, fl, 1'b0, 32'h0, NOPI, 1'b1, 1'b0, 32'h0);
  endfunction
  function automatic void beat(input logic [31:0] pc, input logic fl, input logic ack,
                               input logic [31:0] rd, input logic [31:0] addr);
    add(pc, fl, ack, rd, NOPI, 1'b1, 1'b1, addr);
  endfunction
  function automatic void hitv(input logic [31:0] pc, input logic ack, input logic [31:0] instr);
    add(pc, 1'b0, ack, ack ? 32'hDEAD_BEEF : 32'h0, instr, 1'b0, 1'b0, 32'h0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic apply(input int i);
    PC       = tv[i].pc;
    Flush    = tv[i].fl;
    MemAck   = tv[i].ack;
    MemRData = tv[i].rd;
    #1;
    chk($sformatf("v%0d Instr", i),   Instr,          tv[i].instr);
    chk($sformatf("v%0d Stall", i),   {31'b0, Stall}, {31'b0, tv[i].stall});
    chk($sformatf("v%0d MemReq", i),  {31'b0, MemReq},{31'b0, tv[i].req});
    chk($sformatf("v%0d MemAddr", i), MemAddr,        tv[i].addr);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // 0..7: cold fill of 0x100 (ack in IDLE ignored), then three hits
    add(32'h100, 1'b0, 1'b1, 32'hFFFF_FFFF, NOPI, 1'b1, 1'b0, 32'h0);
    for (int w = 0; w < 4; w++) beat(32'h100, 1'b0, 1'b1, 32'hA0 + w, 32'h100 + 4*w);
    hitv(32'h100, 1'b0, 32'hA0);
    hitv(32'h10C, 1'b0, 32'hA3);
    hitv(32'h104, 1'b1, 32'hA1);
    // 8..22: same-index line 0x1100 with PC moving and an ack gap, then 0x100 evicted
    miss(32'h1100, 1'b0);
    beat(32'h1100, 1'b0, 1'b0, 32'h0,  32'h1100);
    beat(32'h5000, 1'b0, 1'b1, 32'hB0, 32'h1100);
    beat(32'h5000, 1'b0, 1'b1, 32'hB1, 32'h1104);
    beat(32'h5000, 1'b0, 1'b0, 32'h0,  32'h1108);
    beat(32'h1100, 1'b0, 1'b1, 32'hB2, 32'h1108);
    beat(32'h1100, 1'b0, 1'b1, 32'hB3, 32'h110C);
    hitv(32'h1100, 1'b1, 32'hB0);
    hitv(32'h110C, 1'b0, 32'hB3);
    miss(32'h100, 1'b0);
    for (int w = 0; w < 4; w++) beat(32'h100, 1'b0, 1'b1, 32'hA0 + w, 32'h100 + 4*w);
    hitv(32'h100, 1'b0, 32'hA0);
    // 23..33: flush mid-refill of 0x200 leaves it invalid; second refill then hits
    miss(32'h200, 1'b0);
    beat(32'h200, 1'b0, 1'b1, 32'hC0, 32'h200);
    beat(32'h200, 1'b1, 1'b1, 32'hC1, 32'h204);
    beat(32'h200, 1'b0, 1'b1, 32'hC2, 32'h208);
    beat(32'h200, 1'b0, 1'b1, 32'hC3, 32'h20C);
    miss(32'h200, 1'b0);
    for (int w = 0; w < 4; w++) beat(32'h200, 1'b0, 1'b1, 32'hC0 + w, 32'h200 + 4*w);
    hitv(32'h200, 1'b0, 32'hC0);
    // 34..47: flush in IDLE over a hit, refill, second index coexists
    miss(32'h200, 1'b1);
    miss(32'h200, 1'b0);
    for (int w = 0; w < 4; w++) beat(32'h200, 1'b0, 1'b1, 32'hD0 + w, 32'h200 + 4*w);
    hitv(32'h204, 1'b0, 32'hD1);
    miss(32'h114, 1'b0);
    for (int w = 0; w < 4; w++) beat(32'h114, 1'b0, 1'b1, 32'hE0 + w, 32'h110 + 4*w);
    hitv(32'h114, 1'b0, 32'hE1);
    hitv(32'h208, 1'b0, 32'hD2);
    // 48..50: start 0x300 refill, two beats, then reset
    miss(32'h300, 1'b0);
    beat(32'h300, 1'b0, 1'b1, 32'hF0, 32'h300);
    beat(32'h300, 1'b0, 1'b1, 32'hF1, 32'h304);
    // 51..56: post-reset refill restarts at word 0; other lines were invalidated
    for (int w = 0; w < 4; w++) beat(32'h300, 1'b0, 1'b1, 32'hF0 + w, 32'h300 + 4*w);
    hitv(32'h300, 1'b0, 32'hF0);
    miss(32'h208, 1'b0);

    RST = 1'b0; PC = 32'h100; Flush = 1'b0; MemAck = 1'b0; MemRData = 32'h0;
    #2;
    chk("rst Stall",   {31'b0, Stall},  32'd1);
    chk("rst Instr",   Instr,           NOPI);
    chk("rst MemReq",  {31'b0, MemReq}, 32'd0);
    chk("rst MemAddr", MemAddr,         32'h0);
`ifdef ICACHE_PERF_CNT_EN
    chk("rst HitCnt",  HitCnt,  32'd0);
    chk("rst MissCnt", MissCnt, 32'd0);
`endif
    @(posedge CLK);
    #1;
    RST = 1'b1;

    for (int i = 0; i < 8; i++) apply(i);
`ifdef ICACHE_PERF_CNT_EN
    chk("perf HitCnt",  HitCnt,  32'd3);
    chk("perf MissCnt", MissCnt, 32'd1);
`endif
    for (int i = 8; i < 51; i++) apply(i);

    // Two beats of 0x300 taken; reset asynchronously mid-refill.
    MemAck = 1'b0;
    RST = 1'b0;
    #1;
    chk("abort MemReq",  {31'b0, MemReq}, 32'd0);
    chk("abort MemAddr", MemAddr,         32'h0);
    chk("abort Stall",   {31'b0, Stall},  32'd1);
    chk("abort Instr",   Instr,           NOPI);
    #2;
    RST = 1'b1;
    #1;
    chk("post-rst Stall",  {31'b0, Stall},  32'd1);
    chk("post-rst MemReq", {31'b0, MemReq}, 32'd0);
    @(posedge CLK);
    #1;
    for (int i = 51; i < tv.size(); i++) apply(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
